branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_pkg.sv | 30 +++
 rtl/bht_table.sv | 32 +++
 rtl/branch_resolve_unit.sv | 95 +++++++++
 tb/tb_branch_resolve_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared branch opcodes, predictor reset value and 2-bit counter helpers.
package branch_pkg;

    localparam logic [5:0] OpBeq  = 6'd18;
    localparam logic [5:0] OpBne  = 6'd19;
    localparam logic [5:0] OpBgtz = 6'd20;
    localparam logic [5:0] OpBlez = 6'd21;
    localparam logic [5:0] OpBltz = 6'd22;
    localparam logic [5:0] OpJ    = 6'd23;
    localparam logic [5:0] OpJr   = 6'd24;
    localparam logic [5:0] OpJal  = 6'd25;
    localparam logic [5:0] OpBgez = 6'd26;

    // Weakly not taken.
    localparam logic [1:0] BhtCntReset = 2'b01;

    // Only conditional branches train the predictor.
    function automatic logic is_cond_op(input logic [5:0] op);
        return (op == OpBeq) || (op == OpBne) || (op == OpBgtz) ||
               (op == OpBlez) || (op == OpBltz) || (op == OpBgez);
    endfunction

    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == 2'b11) ? cnt : cnt + 2'b01;
        end
        return (cnt == 2'b00) ? cnt : cnt - 2'b01;
    endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table: 2-bit saturating counters, one combinational read
// port and one saturating-update write port, so reads see pre-update values.
module bht_table
    import branch_pkg::*;
#(
    parameter int unsigned Depth = 16,
    localparam int unsigned IdxW = $clog2(Depth)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IdxW-1:0] rd_idx,
    output logic [1:0]      rd_cnt,
    input  logic            wr_en,
    input  logic [IdxW-1:0] wr_idx,
    input  logic            wr_taken
);

    logic [1:0] cnt_q [Depth];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(Depth); i++) begin
                cnt_q[i] <= BhtCntReset;
            end
        end else if (wr_en) begin
            cnt_q[wr_idx] <= sat_step(cnt_q[wr_idx], wr_taken);
        end
    end

    assign rd_cnt = cnt_q[rd_idx];

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branch direction from signed operand compares, trains a bimodal
// predictor, and counts mispredictions.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BHT_DEPTH = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              PredValid,
    input  logic [31:0]       PredPC,
    output logic              PredTaken,
    input  logic              ResValid,
    input  logic [31:0]       ResPC,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [5:0]        BranchControl,
    input  logic              ResPredicted,
    input  logic              Stall,
    output logic              OutValid,
    output logic              OutTaken,
    output logic              Mispredict,
    output logic [CNT_W-1:0]  MispredictCount
);

    localparam int unsigned IdxW = $clog2(BHT_DEPTH);

    logic [IdxW-1:0] pred_idx;
    logic [IdxW-1:0] res_idx;
    logic [1:0]      pred_cnt;
    logic            res_taken;
    logic            bht_wr_en;
    logic            a_neg;
    logic            a_zero;
    logic            unused_pc;

    assign pred_idx  = PredPC[IdxW+1:2];
    assign res_idx   = ResPC[IdxW+1:2];
    assign unused_pc = ^{PredPC[31:IdxW+2], PredPC[1:0], ResPC[31:IdxW+2], ResPC[1:0]};

    assign a_neg  = A[DATA_W-1];
    assign a_zero = (A == '0);

    always_comb begin
        res_taken = 1'b0;
        case (BranchControl)
            OpBeq:             res_taken = (A == B);
            OpBne:             res_taken = (A != B);
            OpBgtz:            res_taken = !a_neg && !a_zero;
            OpBlez:            res_taken = a_neg || a_zero;
            OpBltz:            res_taken = a_neg;
            OpBgez:            res_taken = !a_neg;
            OpJ, OpJr, OpJal:  res_taken = 1'b1;
            default:           res_taken = 1'b0;
        endcase
    end

    assign bht_wr_en = ResValid && !Stall && is_cond_op(BranchControl);

    bht_table #(
        .Depth (BHT_DEPTH)
    ) u_bht (
        .clk      (Clk),
        .rst_n    (Reset),
        .rd_idx   (pred_idx),
        .rd_cnt   (pred_cnt),
        .wr_en    (bht_wr_en),
        .wr_idx   (res_idx),
        .wr_taken (res_taken)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            PredTaken       <= 1'b0;
            OutValid        <= 1'b0;
            OutTaken        <= 1'b0;
            Mispredict      <= 1'b0;
            MispredictCount <= '0;
        end else if (!Stall) begin
            if (PredValid) begin
                PredTaken <= pred_cnt[1];
            end
            OutValid   <= ResValid;
            OutTaken   <= ResValid && res_taken;
            Mispredict <= ResValid && (res_taken != ResPredicted);
            // Counts the mispredict currently on the output, once it retires.
            if (Mispredict && (MispredictCount != {CNT_W{1'b1}})) begin
                MispredictCount <= MispredictCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: expected resolve/lookup results
// are queued at issue and compared when the registered outputs appear.
module tb_branch_resolve_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        PredValid;
    logic [31:0] PredPC;
    logic        PredTaken;
    logic        ResValid;
    logic [31:0] ResPC;
    logic [31:0] A;
    logic [31:0] B;
    logic [5:0]  BranchControl;
    logic        ResPredicted;
    logic        Stall;
    logic        OutValid;
    logic        OutTaken;
    logic        Mispredict;
    logic [15:0] MispredictCount;

    logic        pred_taken2;
    logic        out_valid2;
    logic        out_taken2;
    logic        mispredict2;
    logic [1:0]  mispredict_count2;

    always #5 Clk = ~Clk;

    branch_resolve_unit dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .PredValid       (PredValid),
        .PredPC          (PredPC),
        .PredTaken       (PredTaken),
        .ResValid        (ResValid),
        .ResPC           (ResPC),
        .A               (A),
        .B               (B),
        .BranchControl   (BranchControl),
        .ResPredicted    (ResPredicted),
        .Stall           (Stall),
        .OutValid        (OutValid),
        .OutTaken        (OutTaken),
        .Mispredict      (Mispredict),
        .MispredictCount (MispredictCount)
    );

    branch_resolve_unit #(
        .CNT_W (2)
    ) dut2 (
        .Clk             (Clk),
        .Reset           (Reset),
        .PredValid       (PredValid),
        .PredPC          (PredPC),
        .PredTaken       (pred_taken2),
        .ResValid        (ResValid),
        .ResPC           (ResPC),
        .A               (A),
        .B               (B),
        .BranchControl   (BranchControl),
        .ResPredicted    (ResPredicted),
        .Stall           (Stall),
        .OutValid        (out_valid2),
        .OutTaken        (out_taken2),
        .Mispredict      (mispredict2),
        .MispredictCount (mispredict_count2)
    );

    typedef struct packed {
        logic taken;
        logic mis;
    } res_t;

    res_t       exp_res_q[$];
    logic       exp_pred_q[$];
    logic [1:0] m_bht [16];
    int         m_cnt;
    logic       m_mis;
    logic       m_pred;
    logic       res_pending;
    logic       pred_pending;
    logic       upd_pending;
    logic [3:0] upd_idx;
    logic       upd_taken;
    int         n_tests = 0;
    int         n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_taken(input logic [5:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        case (op)
            6'd18:               return a == b;
            6'd19:               return a != b;
            6'd20:               return $signed(a) > 0;
            6'd21:               return $signed(a) <= 0;
            6'd22:               return $signed(a) < 0;
            6'd26:               return $signed(a) >= 0;
            6'd23, 6'd24, 6'd25: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
        m_cnt  = 0;
        m_mis  = 1'b0;
        m_pred = 1'b0;
        exp_res_q.delete();
        exp_pred_q.delete();
    endtask

    task automatic issue_res(input logic [31:0] pc, input logic [5:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic pred);
        logic t;
        t = ref_taken(op, a, b);
        ResValid      = 1'b1;
        ResPC         = pc;
        BranchControl = op;
        A             = a;
        B             = b;
        ResPredicted  = pred;
        exp_res_q.push_back('{taken: t, mis: t != pred});
        res_pending = 1'b1;
        upd_pending = (op >= 6'd18 && op <= 6'd22) || op == 6'd26;
        upd_idx     = pc[5:2];
        upd_taken   = t;
    endtask

    task automatic issue_lookup(input logic [31:0] pc);
        PredValid = 1'b1;
        PredPC    = pc;
        exp_pred_q.push_back(m_bht[pc[5:2]][1]);
        pred_pending = 1'b1;
    endtask

    task automatic tick_check();
        res_t e;
        @(posedge Clk);
        #1;
        if (!Reset) begin
            model_reset();
        end else if (!Stall) begin
            if (m_mis && m_cnt != 16'hFFFF) m_cnt++;
            if (res_pending) begin
                e = exp_res_q.pop_front();
                check("out_valid", 32'(OutValid), 32'd1);
                check("out_taken", 32'(OutTaken), 32'(e.taken));
                check("mispredict", 32'(Mispredict), 32'(e.mis));
                m_mis = e.mis;
                if (upd_pending) begin
                    if (upd_taken && m_bht[upd_idx] != 2'b11) m_bht[upd_idx]++;
                    else if (!upd_taken && m_bht[upd_idx] != 2'b00) m_bht[upd_idx]--;
                end
            end else begin
                check("out_valid_idle", 32'(OutValid), 32'd0);
                m_mis = 1'b0;
            end
            if (pred_pending) begin
                m_pred = exp_pred_q.pop_front();
            end
            check("pred_taken", 32'(PredTaken), 32'(m_pred));
            check("mis_count", 32'(MispredictCount), 32'(m_cnt));
        end
        PredValid    = 1'b0;
        ResValid     = 1'b0;
        res_pending  = 1'b0;
        pred_pending = 1'b0;
        upd_pending  = 1'b0;
    endtask

    logic [31:0] sg_pc   [7] = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h20, 32'h14};
    logic [5:0]  sg_op   [7] = '{6'd22, 6'd20, 6'd26, 6'd21, 6'd19, 6'd7, 6'd20};
    logic [31:0] sg_a    [7] = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'h8000_0000, 32'h3, 32'h0,
                                 32'h7FFF_FFFF};
    logic [31:0] sg_b    [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h3, 32'h0, 32'h0};
    logic        sg_pred [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        Reset = 1'b0; Stall = 1'b0; PredValid = 1'b0; PredPC = '0; ResValid = 1'b0;
        ResPC = '0; A = '0; B = '0; BranchControl = '0; ResPredicted = 1'b0;
        res_pending = 1'b0; pred_pending = 1'b0; upd_pending = 1'b0;
        upd_idx = '0; upd_taken = 1'b0;
        model_reset();
        tick_check();
        tick_check();
        check("rst_pred_taken", 32'(PredTaken), 32'd0);
        check("rst_out_valid", 32'(OutValid), 32'd0);
        check("rst_out_taken", 32'(OutTaken), 32'd0);
        check("rst_mispredict", 32'(Mispredict), 32'd0);
        check("rst_count", 32'(MispredictCount), 32'd0);
        Reset = 1'b1;

        issue_lookup(32'h40);
        tick_check();
        check("lookup_after_reset", 32'(PredTaken), 32'd0);

        // Three back-to-back taken beq at 0x40, all predicted not taken.
        for (int i = 0; i < 3; i++) begin
            issue_res(32'h40, 6'd18, 32'd5, 32'd5, 1'b0);
            tick_check();
        end
        check("count_after_three", 32'(MispredictCount), 32'd2);
        check("bht_0x40_model", 32'(m_bht[0]), 32'd3);
        issue_lookup(32'h40);
        tick_check();
        check("lookup_0x40_trained", 32'(PredTaken), 32'd1);

        for (int i = 0; i < 7; i++) begin
            issue_res(sg_pc[i], sg_op[i], sg_a[i], sg_b[i], sg_pred[i]);
            tick_check();
        end

        issue_res(32'h24, 6'd25, 32'd0, 32'd0, 1'b0);
        tick_check();
        check("jal_taken", 32'(OutTaken), 32'd1);
        check("jal_mispredict", 32'(Mispredict), 32'd1);
        issue_lookup(32'h24);
        tick_check();
        check("jal_bht_unchanged", 32'(PredTaken), 32'd0);

        // Same-cycle lookup and update of index 3.
        issue_lookup(32'h0C);
        issue_res(32'h0C, 6'd18, 32'd1, 32'd1, 1'b0);
        tick_check();
        check("rbw_old_value", 32'(PredTaken), 32'd0);
        issue_lookup(32'h0C);
        tick_check();
        check("rbw_new_value", 32'(PredTaken), 32'd1);
        tick_check();

        // Stall with live requests: everything must hold.
        issue_res(32'h30, 6'd18, 32'd1, 32'd2, 1'b1);
        tick_check();
        Stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ResValid = 1'b1; ResPC = 32'h30; BranchControl = 6'd19; A = 32'd1; B = 32'd2;
            ResPredicted = 1'b0; PredValid = 1'b1; PredPC = 32'h24;
            @(posedge Clk);
            #1;
            check("stall_out_valid", 32'(OutValid), 32'd1);
            check("stall_out_taken", 32'(OutTaken), 32'd0);
            check("stall_mispredict", 32'(Mispredict), 32'd1);
            check("stall_pred_taken", 32'(PredTaken), 32'(m_pred));
            check("stall_count", 32'(MispredictCount), 32'(m_cnt));
        end
        Stall = 1'b0; ResValid = 1'b0; PredValid = 1'b0;
        tick_check();
        issue_lookup(32'h30);
        tick_check();
        check("stall_no_bht_update", 32'(PredTaken), 32'd0);

        // Reset wins over stall and drops the in-flight request.
        issue_res(32'h24, 6'd25, 32'd0, 32'd0, 1'b0);
        issue_lookup(32'h0C);
        tick_check();
        Reset = 1'b0; Stall = 1'b1;
        ResValid = 1'b1; ResPC = 32'h0C; BranchControl = 6'd18; A = '0; B = '0;
        ResPredicted = 1'b0;
        exp_res_q.delete(); exp_pred_q.delete();
        tick_check();
        check("rst_stall_pred", 32'(PredTaken), 32'd0);
        check("rst_stall_valid", 32'(OutValid), 32'd0);
        check("rst_stall_taken", 32'(OutTaken), 32'd0);
        check("rst_stall_mis", 32'(Mispredict), 32'd0);
        check("rst_stall_count", 32'(MispredictCount), 32'd0);
        Reset = 1'b1; Stall = 1'b0;
        issue_lookup(32'h0C);
        tick_check();
        check("bht_reset_value", 32'(PredTaken), 32'd0);

        for (int i = 0; i < 5; i++) begin
            issue_res(32'h24, 6'd25, 32'd0, 32'd0, 1'b0);
            tick_check();
        end
        tick_check();
        tick_check();
        check("narrow_count_sat", 32'(mispredict_count2), 32'd3);
        check("wide_count", 32'(MispredictCount), 32'd5);
        check("queue_empty", 32'(exp_res_q.size() + exp_pred_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
